// File: rtl/pad_pkg.sv
// Shared types for the border-padding stream block: pad mode encoding and FSM states.
package pad_pkg;

   typedef enum logic [1:0] {
      MODE_ZERO   = 2'd0,
      MODE_CONST  = 2'd1,
      MODE_BYPASS = 2'd2,
      MODE_RSVD   = 2'd3
   } pad_mode_t;

   typedef enum logic [1:0] {
      S_TOP    = 2'd0,
      S_ROW    = 2'd1,
      S_BOTTOM = 2'd2
   } pad_state_t;

   // The reserved code is folded onto ZERO so the rest of the design sees three modes.
   function automatic pad_mode_t norm_mode(input logic [1:0] m);
      pad_mode_t r;
      case (m)
         2'd1:    r = MODE_CONST;
         2'd2:    r = MODE_BYPASS;
         default: r = MODE_ZERO;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pad_stream.sv
// Streams a WIDTH x HEIGHT raster frame out with a PAD-pixel border (zero or constant),
// or passes it through unpadded in BYPASS mode, behind a single-stage output register.
module pad_stream
   import pad_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int WIDTH  = 6,
   parameter int HEIGHT = 6,
   parameter int PAD    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] pad_value,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic              sof_out,
   output logic              eol_out,
   output logic              frame_done
);

   localparam int PW = WIDTH + 2 * PAD;
   localparam int PH = HEIGHT + 2 * PAD;
   localparam int XW = $clog2(PW + 1);
   localparam int YW = $clog2(PH + 1);

   localparam logic [XW-1:0] X_PIX_LO = XW'(PAD);
   localparam logic [XW-1:0] X_PIX_HI = XW'(PAD + WIDTH);
   localparam logic [XW-1:0] X_LAST   = XW'(PW - 1);
   localparam logic [XW-1:0] X_BLAST  = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_TOP_E  = YW'(PAD - 1);
   localparam logic [YW-1:0] Y_ROW_E  = YW'(PAD + HEIGHT - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(PH - 1);
   localparam logic [YW-1:0] Y_BLAST  = YW'(HEIGHT - 1);

   pad_state_t        state_q, state_d;
   pad_mode_t         mode_q, mode_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [DATA_W-1:0] padv_q, padv_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              sof_q, sof_d;
   logic              eol_q, eol_d;
   logic              last_q, last_d;
   logic              done_q, done_d;

   logic              at_origin_s, bypass_s, in_pix_s, advance_s, load_s;
   logic              row_end_s, frame_end_s;
   pad_mode_t         cur_mode_s;
   logic [DATA_W-1:0] cur_val_s;

   // At beat (0,0) the live mode/value apply; afterwards the frame-latched copies do.
   assign at_origin_s = (x_q == '0) && (y_q == '0);
   assign cur_mode_s  = at_origin_s ? norm_mode(mode) : mode_q;
   assign cur_val_s   = at_origin_s ? pad_value : padv_q;
   assign bypass_s    = (cur_mode_s == MODE_BYPASS);
   assign in_pix_s    = bypass_s || ((state_q == S_ROW) && (x_q >= X_PIX_LO) && (x_q < X_PIX_HI));
   assign advance_s   = !valid_q || ready_in;
   assign ready_out   = reset_n && advance_s && in_pix_s;
   assign load_s      = advance_s && (!in_pix_s || valid_in);
   assign row_end_s   = (x_q == (bypass_s ? X_BLAST : X_LAST));
   assign frame_end_s = row_end_s && (y_q == (bypass_s ? Y_BLAST : Y_LAST));

   // Next-state: position/FSM stepping and output-register load on each accepted advance.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      padv_d  = padv_q;
      data_d  = data_q;
      valid_d = valid_q;
      sof_d   = sof_q;
      eol_d   = eol_q;
      last_d  = last_q;
      done_d  = valid_q && ready_in && last_q;
      if (load_s) begin
         valid_d = 1'b1;
         sof_d   = at_origin_s;
         eol_d   = row_end_s;
         last_d  = frame_end_s;
         if (in_pix_s) begin
            data_d = data_in;
         end else if (cur_mode_s == MODE_CONST) begin
            data_d = cur_val_s;
         end else begin
            data_d = '0;
         end
         if (at_origin_s) begin
            mode_d = cur_mode_s;
            padv_d = cur_val_s;
         end else begin
            mode_d = mode_q;
            padv_d = padv_q;
         end
         if (row_end_s) begin
            x_d = '0;
            y_d = frame_end_s ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
            y_d = y_q;
         end
         if (row_end_s && !bypass_s) begin
            case (state_q)
               S_TOP:    state_d = (y_q == Y_TOP_E) ? S_ROW    : S_TOP;
               S_ROW:    state_d = (y_q == Y_ROW_E) ? S_BOTTOM : S_ROW;
               S_BOTTOM: state_d = (y_q == Y_LAST)  ? S_TOP    : S_BOTTOM;
               default:  state_d = S_TOP;
            endcase
         end else begin
            state_d = state_q;
         end
      end else if (advance_s) begin
         valid_d = 1'b0;
         sof_d   = 1'b0;
         eol_d   = 1'b0;
         last_d  = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_TOP;
         mode_q  <= MODE_ZERO;
         x_q     <= '0;
         y_q     <= '0;
         padv_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         padv_q  <= padv_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign sof_out    = sof_q;
   assign eol_out    = eol_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_pad_stream.sv
// Randomized self-checking bench for pad_stream: expected beats come from a frame-level
// model (border / pixel classification per output coordinate) held in a queue.
module tb_pad_stream;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int P  = 2;
   localparam int PW = W + 2 * P;
   localparam int PH = H + 2 * P;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    mode;
   logic [DW-1:0] pad_value, data_in, data_out;
   logic          valid_in, ready_out, valid_out, ready_in, sof_out, eol_out, frame_done;

   always #5 clk = ~clk;

   pad_stream #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H), .PAD(P)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .pad_value(pad_value),
      .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
      .sof_out(sof_out), .eol_out(eol_out), .frame_done(frame_done)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          sof;
      logic          eol;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] pix[W*H];
   int            n_checks = 0;
   int            n_pass = 0;
   int            nbeats, exp_total;
   bit            stall_prev, done_exp, started, gapless;
   logic [DW-1:0] s_data;
   logic          s_sof, s_eol;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, expv);
   endtask

   // Expected frame: every output coordinate is either border or an input pixel.
   task automatic build_frame(input logic [1:0] md, input logic [DW-1:0] pv);
      bit            byp = (md == 2'd2);
      logic [DW-1:0] bv = (md == 2'd1) ? pv : 8'h00;
      int            fw = byp ? W : PW;
      int            fh = byp ? H : PH;
      int            off = byp ? 0 : P;
      beat_t         b;
      for (int y = 0; y < fh; y++) begin
         for (int x = 0; x < fw; x++) begin
            if (x >= off && x < off + W && y >= off && y < off + H) b.d = pix[(y - off) * W + (x - off)];
            else b.d = bv;
            b.sof  = (x == 0 && y == 0);
            b.eol  = (x == fw - 1);
            b.last = (x == fw - 1 && y == fh - 1);
            exp_q.push_back(b);
         end
      end
      for (int i = 0; i < W * H; i++) in_q.push_back(pix[i]);
      exp_total += fw * fh;
   endtask

   task automatic monitor();
      beat_t b;
      if (stall_prev) begin
         chk("hold_valid", valid_out, 1);
         chk("hold_data", data_out, s_data);
         chk("hold_sof", sof_out, s_sof);
         chk("hold_eol", eol_out, s_eol);
      end
      chk("frame_done", frame_done, done_exp);
      if (gapless && started && exp_q.size() > 0) chk("no_gap", valid_out, 1);
      done_exp = 0;
      if (valid_out && ready_in) begin
         nbeats++;
         if (exp_q.size() == 0) begin
            chk("extra_beat", 1, 0);
         end else begin
            b = exp_q.pop_front();
            chk("data", data_out, b.d);
            chk("sof", sof_out, b.sof);
            chk("eol", eol_out, b.eol);
            done_exp = b.last;
            started = 1;
         end
      end
      stall_prev = valid_out && !ready_in;
      s_data = data_out;
      s_sof = sof_out;
      s_eol = eol_out;
   endtask

   task automatic do_reset(input logic [1:0] md, input logic [DW-1:0] pv);
      @(posedge clk); #1;
      reset_n = 1'b0; mode = md; pad_value = pv; valid_in = 1'b0; ready_in = 1'b1;
      @(negedge clk);
      chk("rst_ready_out", ready_out, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_sof", sof_out, 0);
      chk("rst_eol", eol_out, 0);
      chk("rst_done", frame_done, 0);
      exp_q.delete(); in_q.delete();
      stall_prev = 0; done_exp = 0; started = 0; exp_total = 0; nbeats = 0;
      @(posedge clk); #1;
      reset_n = 1'b1; ready_in = 1'b0;
   endtask

   task automatic run(input int rdy_pct, input int vld_pct, input int chg_at,
                      input logic [1:0] chg_mode, input int max_beats);
      int cyc = 0;
      bit acc = 0;
      while (exp_q.size() > 0 && nbeats < max_beats && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (acc && in_q.size() > 0) void'(in_q.pop_front());
         if (cyc == chg_at) begin
            mode = chg_mode;
            pad_value = ~pad_value;
         end
         valid_in = (in_q.size() > 0) && ($urandom_range(99) < vld_pct);
         data_in  = (in_q.size() > 0) ? in_q[0] : 8'($urandom_range(255));
         ready_in = ($urandom_range(99) < rdy_pct);
         @(negedge clk);
         acc = valid_in && ready_out;
         monitor();
      end
      if (nbeats < max_beats && exp_q.size() > 0) chk("timeout_left", exp_q.size(), 0);
   endtask

   task automatic finish_frame();
      @(posedge clk); #1;
      ready_in = 1'b0; valid_in = 1'b0;
      @(negedge clk);
      monitor();
      chk("beat_count", nbeats, exp_total);
   endtask

   task automatic seq_pix();
      for (int i = 0; i < W * H; i++) pix[i] = 8'(i + 1);
   endtask

   task automatic rand_pix();
      for (int i = 0; i < W * H; i++) pix[i] = 8'($urandom_range(255));
   endtask

   initial begin
      logic [1:0]    md;
      logic [DW-1:0] pv;
      reset_n = 1'b0; mode = 2'd0; pad_value = 8'h00; data_in = 8'h00;
      valid_in = 1'b0; ready_in = 1'b0; gapless = 0;

      // ZERO, full throughput, pixels 1..12
      seq_pix(); do_reset(2'd0, 8'h00); build_frame(2'd0, 8'h00);
      run(100, 100, 0, 2'd0, 1000); finish_frame();

      // CONST 0xA5, mode/value changed mid-frame must be ignored
      seq_pix(); do_reset(2'd1, 8'hA5); build_frame(2'd1, 8'hA5);
      run(100, 100, 10, 2'd0, 1000); finish_frame();

      // ZERO with random backpressure and input gaps
      seq_pix(); do_reset(2'd0, 8'h00); build_frame(2'd0, 8'h00);
      run(50, 60, 0, 2'd0, 1000); finish_frame();

      // BYPASS, full throughput and stalled
      seq_pix(); do_reset(2'd2, 8'h33); build_frame(2'd2, 8'h33);
      run(100, 100, 0, 2'd0, 1000); finish_frame();
      rand_pix(); do_reset(2'd2, 8'h00); build_frame(2'd2, 8'h00);
      run(50, 50, 0, 2'd0, 1000); finish_frame();

      // Two back-to-back frames, no idle cycle at the frame boundary
      seq_pix(); do_reset(2'd0, 8'h00); build_frame(2'd0, 8'h00); build_frame(2'd0, 8'h00);
      gapless = 1;
      run(100, 100, 0, 2'd0, 1000); finish_frame();
      gapless = 0;

      // Random modes (including reserved) and pad values
      for (int k = 0; k < 6; k++) begin
         md = 2'($urandom_range(3));
         pv = 8'($urandom_range(255));
         rand_pix(); do_reset(md, pv); build_frame(md, pv);
         run(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 2'd0, 1000);
         finish_frame();
      end

      // Reset after 20 beats discards the frame; restart at (0,0)
      seq_pix(); do_reset(2'd0, 8'h00); build_frame(2'd0, 8'h00);
      run(100, 100, 0, 2'd0, 20);
      chk("mid_beats", nbeats, 20);
      @(posedge clk); #1;
      reset_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready_out", ready_out, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", valid_out, 0);
      @(negedge clk);
      chk("restart_valid", valid_out, 1);
      chk("restart_sof", sof_out, 1);
      chk("restart_data", data_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
